dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 Parameter DATA_W, 16, data word width.
REQ-003 Parameter ADDR_W, 16, address width.
REQ-004 Parameter DEPTH, 1024, number of valid memory words.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 a_req, a_we  in  1 each  port A (CPU) request and write enable.
REQ-008 a_addr, a_wdata  in  ADDR_W, DATA_W  port A address and write data.
REQ-009 a_gnt, a_rvalid  out  1 each  port A accept pulse and read-data-valid pulse.
REQ-010 a_rdata  out  DATA_W  port A read data.
REQ-011 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same widths/directions  port B (DMA).
REQ-012 mem_we  out  1  memory write strobe.
REQ-013 mem_addr, mem_wdata  out  ADDR_W, DATA_W  memory address and write data.
REQ-014 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented.
REQ-015 a_cnt, b_cnt  out  16 each  saturating granted-access counters.
REQ-016 err  out  1  sticky address-range error (REQ-032).

Function
REQ-017 FSM states IDLE, ACC, RESP; reset state IDLE.
REQ-018 IDLE: no request -> stay; otherwise select winner, register its we/addr/wdata, -> ACC.
REQ-019 Arbitration round-robin: both requesting -> port not granted last wins; last-grant pointer resets to B (A wins first tie).
REQ-020 ACC: mem_addr/mem_wdata driven from latched values, mem_we = latched we, winner's gnt high exactly this cycle; write -> IDLE, read -> RESP.
REQ-021 RESP: winner's rdata registered from mem_rdata, winner's rvalid high exactly one cycle (next cycle), -> IDLE.
REQ-022 Latency: req seen in IDLE cycle N -> gnt in N+1; read rvalid in N+3.
REQ-023 Requester holds req/we/addr/wdata stable until gnt; deasserting earlier is a protocol violation, no behaviour defined.
REQ-024 Requests arriving in ACC/RESP wait; sampled only in IDLE.
REQ-025 mem_we low in every state except ACC-write; mem_addr/mem_wdata hold last latched value outside ACC.
REQ-026 rdata of each port holds last read value until next rvalid for that port.
REQ-027 gnt and rvalid never high for both ports in the same cycle.
REQ-028 Counter increments on that port's gnt; saturates at 16'hFFFF, no wrap.

Reset
REQ-029 rst_n low forces immediately: state IDLE, pointer B, all gnt/rvalid/mem_we 0, rdata/mem_addr/mem_wdata 0, counters 0, err 0.
REQ-030 Reset mid-ACC/RESP aborts the access: no rvalid issued, no further mem_we after rst_n deasserts.
REQ-031 First arbitration on the first rising edge with rst_n high.

Configuration
REQ-032 DM_ARB_ADDR_CHECK_EN defined: latched addr >= DEPTH -> access still granted, mem_we forced 0, read returns 0 with rvalid, err set sticky until reset.
REQ-033 DM_ARB_ADDR_CHECK_EN undefined: no range check, address passed unmodified, err tied 0.

Structure
REQ-034 Shared package dm_pkg: state enum (IDLE, ACC, RESP), port-id type (PORT_A, PORT_B), DATA_W/ADDR_W/DEPTH defaults.
REQ-035 One sub-module, rr_arb2: two-requester round-robin picker (req pair + pointer -> one-hot winner); FSM, latches, counters in dm_arbiter.

Verification
REQ-036 A write 16'h1DFE @16'h0000 alone -> a_gnt 1 cycle later, mem_we with that addr/data, a_cnt=1.
REQ-037 A then read @16'h0000, mem model returns 16'h1DFE -> a_rvalid 3 cycles after req, a_rdata=16'h1DFE.
REQ-038 A and B both requesting continuously, 4 accesses -> grant order A,B,A,B; a_cnt=b_cnt=2.
REQ-039 B read @16'h0005 while A write pending; rst_n pulsed low during RESP -> no b_rvalid, all outputs 0, next grant to A.
REQ-040 With DM_ARB_ADDR_CHECK_EN, write 16'hA001 @16'h0400 -> gnt issued, mem_we stays 0, err=1 until reset.
REQ-041 Force a_cnt to 16'hFFFF, one more A grant -> a_cnt remains 16'hFFFF.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and defaults for the two-port memory arbiter (dm_arbiter, rr_arb2).
package dm_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 1024;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a tie the port that did not win last time wins.
module rr_arb2
  import dm_pkg::*;
(
  input  logic [1:0] req,   // bit 0 = port A, bit 1 = port B
  input  port_e      last,
  output logic [1:0] win
);

  always_comb begin
    // NOTE: default assignment first, so every path assigns win and no latch is inferred.
    win = req;
    if (req == 2'b11) begin
      win = (last == PORT_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// CPU/DMA single-memory arbiter: IDLE -> ACC -> (RESP) access FSM with round-robin pick.
// Optional macro DM_ARB_ADDR_CHECK_EN: suppress out-of-range accesses and flag a sticky err.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  b_cnt,
  output logic              err
);

  state_e            state;
  port_e             owner;     // current winner, doubles as the last-grant pointer
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              bad_addr;
  logic [1:0]        win;
  logic              in_acc;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] resp_data;

  rr_arb2 u_rr_arb2 (
    .req  ({b_req, a_req}),
    .last (owner),
    .win  (win)
  );

  assign in_acc    = (state == ACC);
  assign pick_addr = win[1] ? b_addr : a_addr;
  assign a_gnt     = in_acc && (owner == PORT_A);
  assign b_gnt     = in_acc && (owner == PORT_B);
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_we    = in_acc && lat_we && !bad_addr;
  assign resp_data = bad_addr ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= PORT_B;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of order.
      unique case (state)
        IDLE: begin
          if (|win) begin
            owner     <= win[1] ? PORT_B : PORT_A;
            lat_we    <= win[1] ? b_we : a_we;
            lat_addr  <= pick_addr;
            lat_wdata <= win[1] ? b_wdata : a_wdata;
            state     <= ACC;
          end
        end
        ACC:     state <= lat_we ? IDLE : RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is captured at the end of RESP, so rvalid lands one cycle after RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (state == RESP) begin
        if (owner == PORT_A) begin
          a_rvalid <= 1'b1;
          a_rdata  <= resp_data;
        end else begin
          b_rvalid <= 1'b1;
          b_rdata  <= resp_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_gnt) a_cnt <= sat_inc(a_cnt);
      if (b_gnt) b_cnt <= sat_inc(b_cnt);
    end
  end

  // An empty block elaborates only for an unusable DEPTH; it keeps the parameter referenced.
  if (DEPTH < 1) begin : g_depth_invalid
  end

`ifdef DM_ARB_ADDR_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_addr <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == IDLE && (|win)) bad_addr <= ({1'b0, pick_addr} >= DEPTH_L);
      if (in_acc && bad_addr) err <= 1'b1;
    end
  end
`else
  assign bad_addr = 1'b0;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic vs a transaction model.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   a_cnt, b_cnt;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            exp_last_b;
  logic [15:0]   exp_a_cnt, exp_b_cnt;

  always #5 clk = ~clk;

  dm_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .err(err)
  );

  function automatic logic [DW-1:0] pattern(input int i);
    return 16'(i * 37 + 16'h5A00);
  endfunction

  // Synchronous memory: read data valid one cycle after the address; preloaded on first edge.
  logic [DW-1:0] tb_mem [DEPTH];
  bit            mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= pattern(i);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_we) tb_mem[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr[9:0]];
    end
  end

  // Both ports must never be granted or answered together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((a_gnt && b_gnt) || (a_rvalid && b_rvalid)) begin
        errors++;
        $display("FAIL exclusive: gnt=%b%b rvalid=%b%b required at most one each",
                 a_gnt, b_gnt, a_rvalid, b_rvalid);
      end
    end
  end

  task automatic drive_quiet();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic settle();
    drive_quiet();
    repeat (3) @(negedge clk);
  endtask

  task automatic apply_reset();
    drive_quiet();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_last_b = 1'b1;
    exp_a_cnt = '0;
    exp_b_cnt = '0;
  endtask

  task automatic test_reset();
    drive_quiet();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 000000", {a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we, err});
    end
    checks++;
    if (a_rdata !== 16'h0 || b_rdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h required all 0", a_rdata, b_rdata, mem_addr, mem_wdata);
    end
    checks++;
    if (a_cnt !== 16'h0 || b_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_cnt: got %h %h required 0 0", a_cnt, b_cnt);
    end
    rst_n = 1;
    exp_last_b = 1'b1;
    exp_a_cnt = '0;
    exp_b_cnt = '0;
  endtask

  task automatic test_write_single();
    settle();
    a_req = 1; a_we = 1; a_addr = 16'h0000; a_wdata = 16'h1DFE;
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
      errors++;
      $display("FAIL write_gnt: got a=%b b=%b required a=1 b=0", a_gnt, b_gnt);
    end
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0000 || mem_wdata !== 16'h1DFE) begin
      errors++;
      $display("FAIL write_mem: got we=%b addr=%h data=%h required 1 0000 1dfe", mem_we, mem_addr, mem_wdata);
    end
    a_req = 0;
    ref_mem[0] = 16'h1DFE;
    exp_last_b = 1'b0;
    exp_a_cnt = sat_inc(exp_a_cnt);
    @(negedge clk);
    checks++;
    if (a_gnt !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse: got gnt=%b we=%b required 0 0", a_gnt, mem_we);
    end
    checks++;
    if (a_cnt !== 16'd1) begin
      errors++;
      $display("FAIL write_cnt: got %0d required 1", a_cnt);
    end
  endtask

  task automatic test_read_latency();
    int  seen;
    bit  got_gnt;
    settle();
    a_req = 1; a_we = 0; a_addr = 16'h0000;
    seen = 0;
    got_gnt = 0;
    for (int c = 1; c <= 8 && seen == 0; c++) begin
      @(negedge clk);
      if (a_gnt === 1'b1 && !got_gnt) begin
        got_gnt = 1;
        a_req = 0;
        checks++;
        if (c != 1 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL read_gnt: got cycle %0d we=%b required cycle 1 we=0", c, mem_we);
        end
      end
      if (a_rvalid === 1'b1) seen = c;
    end
    exp_last_b = 1'b0;
    exp_a_cnt = sat_inc(exp_a_cnt);
    checks++;
    if (seen != 3 || a_rdata !== 16'h1DFE) begin
      errors++;
      $display("FAIL read_latency: got rvalid at %0d data %h required 3 1dfe", seen, a_rdata);
    end
    @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 16'h1DFE) begin
      errors++;
      $display("FAIL read_hold: got rvalid=%b data=%h required 0 1dfe", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_addr_check();
    settle();
    a_req = 1; a_we = 1; a_addr = 16'h0400; a_wdata = 16'hA001;
    @(negedge clk);
    a_req = 0;
    exp_last_b = 1'b0;
    exp_a_cnt = sat_inc(exp_a_cnt);
`ifdef DM_ARB_ADDR_CHECK_EN
    checks++;
    if (a_gnt !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL range_write: got gnt=%b we=%b required 1 0", a_gnt, mem_we);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL range_err: got %b required 1", err);
    end
    a_req = 1; a_we = 0; a_addr = 16'h0400;
    @(negedge clk);
    a_req = 0;
    exp_a_cnt = sat_inc(exp_a_cnt);
    repeat (2) @(negedge clk);
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 16'h0000 || err !== 1'b1) begin
      errors++;
      $display("FAIL range_read: got rvalid=%b data=%h err=%b required 1 0000 1", a_rvalid, a_rdata, err);
    end
`else
    checks++;
    if (a_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0400 || mem_wdata !== 16'hA001) begin
      errors++;
      $display("FAIL nocheck_write: got gnt=%b we=%b addr=%h data=%h required 1 1 0400 a001",
               a_gnt, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[0] = 16'hA001;  // bench memory decodes only the low 10 address bits
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL nocheck_err: got %b required 0", err);
    end
`endif
  endtask

  task automatic test_round_robin();
    int order [4];
    int n;
    int expected [4];
    expected = '{0, 1, 0, 1};
    apply_reset();
    a_req = 1; a_we = 1; a_addr = 16'd10; a_wdata = 16'hAAAA;
    b_req = 1; b_we = 1; b_addr = 16'd20; b_wdata = 16'hBBBB;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (a_gnt === 1'b1) begin order[n] = 0; n++; end
      else if (b_gnt === 1'b1) begin order[n] = 1; n++; end
    end
    drive_quiet();
    ref_mem[10] = 16'hAAAA;
    ref_mem[20] = 16'hBBBB;
    exp_last_b = 1'b1;
    exp_a_cnt = 16'd2;
    exp_b_cnt = 16'd2;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_timeout: got %0d grants required 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != expected[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got port %0d required port %0d", i, order[i], expected[i]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (a_cnt !== exp_a_cnt || b_cnt !== exp_b_cnt) begin
      errors++;
      $display("FAIL rr_cnt: got %0d %0d required %0d %0d", a_cnt, b_cnt, exp_a_cnt, exp_b_cnt);
    end
  endtask

  task automatic test_reset_mid_resp();
    bit saw_b;
    int first;
    apply_reset();
    b_req = 1; b_we = 0; b_addr = 16'h0005;
    @(negedge clk);
    checks++;
    if (b_gnt !== 1'b1) begin
      errors++;
      $display("FAIL abort_bgnt: got %b required 1", b_gnt);
    end
    b_req = 0;
    a_req = 1; a_we = 1; a_addr = 16'd7; a_wdata = 16'h55AA;
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we, err} !== 6'b0 || a_cnt !== 16'h0 || b_cnt !== 16'h0 ||
        a_rdata !== 16'h0 || b_rdata !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errors++;
      $display("FAIL abort_async: got strobes=%b cnt=%h/%h addr=%h required all 0",
               {a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we, err}, a_cnt, b_cnt, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    exp_last_b = 1'b1;
    exp_a_cnt = '0;
    exp_b_cnt = '0;
    saw_b = 0;
    first = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (b_rvalid === 1'b1 || b_gnt === 1'b1) saw_b = 1;
      if (a_gnt === 1'b1 && first == 0) begin
        first = c;
        a_req = 0;
      end else if (mem_we === 1'b1) begin
        saw_b = 1;
      end
    end
    ref_mem[7] = 16'h55AA;
    exp_last_b = 1'b0;
    exp_a_cnt = 16'd1;
    checks++;
    if (saw_b || first != 1) begin
      errors++;
      $display("FAIL abort_after: got stray_b=%b a_gnt_cycle=%0d required 0 1", saw_b, first);
    end
    checks++;
    if (a_cnt !== 16'd1 || b_cnt !== 16'd0) begin
      errors++;
      $display("FAIL abort_cnt: got %0d %0d required 1 0", a_cnt, b_cnt);
    end
  endtask

  // Called on the cycle where this port's grant is expected.
  task automatic serve(input bit is_b, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    logic [DW-1:0] exp_data;
    checks++;
    if ((is_b ? b_gnt : a_gnt) !== 1'b1 || (is_b ? a_gnt : b_gnt) !== 1'b0) begin
      errors++;
      $display("FAIL rand_gnt: port %0d got a=%b b=%b required only port %0d", is_b, a_gnt, b_gnt, is_b);
    end
    checks++;
    if (mem_we !== we || mem_addr !== ad || (we && mem_wdata !== wd)) begin
      errors++;
      $display("FAIL rand_mem: got we=%b addr=%h data=%h required %b %h %h", mem_we, mem_addr, mem_wdata, we, ad, wd);
    end
    if (is_b) b_req = 0; else a_req = 0;
    exp_last_b = is_b;
    if (is_b) exp_b_cnt = sat_inc(exp_b_cnt); else exp_a_cnt = sat_inc(exp_a_cnt);
    if (we) begin
      ref_mem[ad[9:0]] = wd;
    end else begin
      exp_data = ref_mem[ad[9:0]];
      repeat (2) @(negedge clk);
      checks++;
      if ((is_b ? b_rvalid : a_rvalid) !== 1'b1 || (is_b ? b_rdata : a_rdata) !== exp_data) begin
        errors++;
        $display("FAIL rand_read: port %0d got rvalid=%b data=%h required 1 %h", is_b,
                 is_b ? b_rvalid : a_rvalid, is_b ? b_rdata : a_rdata, exp_data);
      end
    end
  endtask

  task automatic test_random(input int n);
    int            sel;
    bit            wa, wb, first_b, last_we;
    logic          we_a, we_b;
    logic [AW-1:0] ad_a, ad_b;
    logic [DW-1:0] wd_a, wd_b;
    settle();
    for (int t = 0; t < n; t++) begin
      sel  = $urandom_range(0, 2);
      wa   = (sel != 1);
      wb   = (sel != 0);
      we_a = 1'($urandom_range(0, 1));
      we_b = 1'($urandom_range(0, 1));
      ad_a = 16'($urandom_range(0, 31));
      ad_b = 16'($urandom_range(0, 31));
      wd_a = 16'($urandom);
      wd_b = 16'($urandom);
      a_req = wa; a_we = we_a; a_addr = ad_a; a_wdata = wd_a;
      b_req = wb; b_we = we_b; b_addr = ad_b; b_wdata = wd_b;
      first_b = (wa && wb) ? !exp_last_b : wb;
      @(negedge clk);
      if (first_b) serve(1'b1, we_b, ad_b, wd_b); else serve(1'b0, we_a, ad_a, wd_a);
      last_we = first_b ? we_b : we_a;
      if (wa && wb) begin
        repeat (last_we ? 2 : 1) @(negedge clk);
        if (first_b) serve(1'b0, we_a, ad_a, wd_a); else serve(1'b1, we_b, ad_b, wd_b);
        last_we = first_b ? we_a : we_b;
      end
      if (last_we) @(negedge clk);
      checks++;
      if (a_cnt !== exp_a_cnt || b_cnt !== exp_b_cnt) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d %0d required %0d %0d", t, a_cnt, b_cnt, exp_a_cnt, exp_b_cnt);
      end
    end
    drive_quiet();
  endtask

  task automatic test_saturation();
    settle();
    force dut.a_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.a_cnt;
    exp_a_cnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      a_req = 1; a_we = 1; a_addr = 16'd3; a_wdata = 16'(16'h0F00 + k);
      @(negedge clk);
      a_req = 0;
      exp_a_cnt = sat_inc(exp_a_cnt);
      @(negedge clk);
      checks++;
      if (a_cnt !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_cnt[%0d]: got %h required ffff", k, a_cnt);
      end
    end
    checks++;
    if (b_cnt !== exp_b_cnt) begin
      errors++;
      $display("FAIL sat_bcnt: got %0d required %0d", b_cnt, exp_b_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pattern(i);
    test_reset();
    test_write_single();
    test_read_latency();
    test_addr_check();
    test_round_robin();
    test_reset_mid_resp();
    test_random(60);
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
